mem_access_stage: RTL

//  MEM stage of the 5-stage RV32 pipeline, between the EX/MEM register and mem_writeback_pipeline.

---
 rtl/mem_access_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory loads/stores over a req/ack handshake,
// stalls upstream while an access is outstanding, and drives the mem_* bundle.
// Ports:
//   clk, rst (sync, active-high)
//   ex_*    : EX/MEM register contents (valid, alu result, store data, op bits)
//   stall   : hold EX/MEM and earlier stages while an access is in flight
//   dmem_*  : data-memory request (req/we/addr/wdata/be) and response (ack/rdata)
//   mem_fault : one-cycle pulse on misaligned access or illegal funct3
//   mem_*   : registered result bundle for mem_writeback_pipeline
module mem_access_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_alu_result,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic [4:0]            ex_reg_dest,
    input  logic                  ex_reg_write,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  mem_fault,
    output logic [DATA_WIDTH-1:0] mem_alu_result,
    output logic [DATA_WIDTH-1:0] mem_mem_data,
    output logic [4:0]            mem_reg_dest,
    output logic                  mem_reg_write
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;

    logic                  is_store, is_load;
    logic                  misalign, illegal, fault;
    logic                  accept;
    logic [1:0]            off;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;

    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    logic [4:0]            r_dest;
    logic                  r_rw;
    logic [7:0]            ld_b;
    logic [15:0]           ld_h;
    logic [DATA_WIDTH-1:0] ld_data;

    logic [DATA_WIDTH-1:0] alu_d, data_d;
    logic [4:0]            dest_d;
    logic                  rw_d, fault_d;

    // A store wins when both read and write are flagged.
    assign is_store = ex_valid & ex_mem_write;
    assign is_load  = ex_valid & ex_mem_read & ~ex_mem_write;
    assign off      = ex_alu_result[1:0];

    always_comb begin
        misalign = 1'b0;
        illegal  = 1'b0;
        case (ex_funct3)
            3'b000: ;
            3'b001: misalign = off[0];
            3'b010: misalign = |off;
            3'b100: illegal = is_store;
            3'b101: begin
                illegal  = is_store;
                misalign = off[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign fault = (is_store | is_load) & (misalign | illegal);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << off;
                st_wdata = {(DATA_WIDTH/8){ex_store_data[7:0]}};
            end
            2'b01: begin
                st_be    = off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {(DATA_WIDTH/16){ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_off)
            2'd0:    ld_b = dmem_rdata[7:0];
            2'd1:    ld_b = dmem_rdata[15:8];
            2'd2:    ld_b = dmem_rdata[23:16];
            default: ld_b = dmem_rdata[31:24];
        endcase
        ld_h = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_f3)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_b[7]}}, ld_b};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_h[15]}}, ld_h};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_b};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_h};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Output register defaults to a bubble; only pass-through ALU ops
    // and completed loads put real content on the WB bundle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        alu_d   = '0;
        data_d  = '0;
        dest_d  = '0;
        rw_d    = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fault) begin
                    fault_d = 1'b1;
                end else if (is_store | is_load) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end else if (ex_valid) begin
                    alu_d  = ex_alu_result;
                    data_d = ex_alu_result;
                    dest_d = ex_reg_dest;
                    rw_d   = ex_reg_write;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    if (!dmem_we) begin
                        alu_d  = ld_data;
                        data_d = ld_data;
                        dest_d = r_dest;
                        rw_d   = r_rw;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_be        <= 4'b0000;
            r_f3           <= 3'b000;
            r_off          <= 2'b00;
            r_dest         <= 5'd0;
            r_rw           <= 1'b0;
            mem_alu_result <= '0;
            mem_mem_data   <= '0;
            mem_reg_dest   <= 5'd0;
            mem_reg_write  <= 1'b0;
            mem_fault      <= 1'b0;
        end else begin
            mem_alu_result <= alu_d;
            mem_mem_data   <= data_d;
            mem_reg_dest   <= dest_d;
            mem_reg_write  <= rw_d;
            mem_fault      <= fault_d;
            if (accept) begin
                dmem_we    <= is_store;
                dmem_addr  <= {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
                dmem_wdata <= st_wdata;
                dmem_be    <= is_store ? st_be : 4'b1111;
                r_f3       <= ex_funct3;
                r_off      <= off;
                r_dest     <= ex_reg_dest;
                r_rw       <= ex_reg_write;
            end
        end
    end

    assign stall    = (state_q == BUSY);
    assign dmem_req = (state_q == BUSY);

endmodule
